keycode_tx: RTL
===============

// Module: keycode_tx
// PURPOSE
// - Transmit end of the keypad code interface: replays a stored multi-digit code
//   onto a 4-bit key bus, one digit per valid/ready handshake, then watches the
//   lock's `locked` output and reports whether the code opened it.
// - Sits between the test/host controller and a keypad lock. Used for
//   auto-unlock, code provisioning checks and lock self-test.
// PARAMETERS
// - NUM_DIGITS  6   digits per code (1..15); digit 0 is sent first
// - GAP_CYCLES  1   idle cycles (key_valid=0) between digits; 0 = back-to-back
// - TIMEOUT     15  max cycles to wait for locked==0 after the last digit (>=1)
// PORTS
// - clk        in   1             rising-edge clock
// - reset      in   1             reset, asynchronous, active-high
// - start      in   1             begin a transmission; sampled only when busy==0
// - code       in   4*NUM_DIGITS  digit i in bits [4i+3:4i]; captured on start
// - key        out  4             digit on the bus; 4'hF when key_valid==0
// - key_valid  out  1             key holds a valid digit
// - key_ready  in   1             lock side accepts the digit this cycle
// - locked     in   1             lock status, 0 = unlocked
// - busy       out  1             transmission in progress
// - done       out  1             1-cycle pulse at completion
// - pass       out  1             last run unlocked the lock; held until next start
// - err        out  1             last run rejected (digit > 9); held until next start
// BEHAVIOUR
// - Reset: state IDLE, key=4'hF, key_valid=0, busy=0, done=0, pass=0, err=0,
//   index/gap/timeout counters cleared. Reset mid-run abandons the sequence.
// - FSM states: IDLE, CHECK, SEND, GAP, WAIT, DONE.
// - IDLE: when start==1, register code, clear pass/err, index=0, go to CHECK.
//   busy=1 from the next cycle.
// - CHECK (1 cycle): if any digit > 9, set err=1, pass=0, go to DONE without
//   driving the bus. Otherwise go to SEND.
// - SEND: key_valid=1, key=digit[index]. Both are held stable until key_ready.
//   Transfer occurs in the cycle where key_valid && key_ready.
//   - After a transfer, if index == NUM_DIGITS-1, go to WAIT.
//   - Otherwise index++ and go to GAP (or stay in SEND when GAP_CYCLES == 0).
// - GAP: key_valid=0 for exactly GAP_CYCLES cycles, then SEND.
// - WAIT: key_valid=0; timer starts at 1 in the first WAIT cycle.
//   - locked==0 in any WAIT cycle: pass=1, go to DONE.
//   - timer == TIMEOUT with locked still 1: pass=0, go to DONE.
//   - locked==0 takes priority over timeout in the same cycle.
// - DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
//   pass and err persist until the next accepted start.
// - start while busy==1 is ignored. start in the DONE cycle is ignored.
// - Latency (GAP_CYCLES=1, key_ready tied 1, N digits):
//   first key_valid 2 cycles after start; last digit at cycle 2N from start.
// CONFIGURATION
// - KEYTX_RETRY_EN defined:
//   - A WAIT timeout on the first attempt does not finish the run.
//   - The FSM waits GAP_CYCLES cycles, resets index=0 and resends the whole code once.
//   - A second timeout gives pass=0. err-path runs never retry.
// - KEYTX_RETRY_EN undefined: the first timeout goes straight to DONE with pass=0.
// TESTING
// - Code 3,3,5,2,5,6; key_ready=1; locked falls 2 cycles after the 6th transfer
//   -> key sequence 3,3,5,2,5,6 with 1-cycle gaps; done pulse; pass=1; err=0.
// - Same code; key_ready low for 3 cycles on digit 2 -> key=5 and key_valid
//   held stable 4 cycles; exactly 6 transfers total.
// - Code containing digit 4'hA -> no key_valid ever; done after CHECK; err=1, pass=0.
// - locked stays 1; TIMEOUT=15 -> done exactly 16 cycles after the last transfer;
//   pass=0. With KEYTX_RETRY_EN: 12 transfers, then done with pass=0.
// - Assert reset during the 3rd digit -> key_valid=0, key=4'hF, busy=0 immediately;
//   a new start sends from digit 0.
// - Pulse start while busy=1 -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/keycode_tx.sv
`default_nettype none
// ============================================================================
// Module      : keycode_tx
// Description : Keypad code transmitter. Replays a stored multi-digit code
//               onto a 4-bit key bus, one digit per valid/ready handshake,
//               then watches the lock's `locked` output and reports whether
//               the code opened it (pass) or was rejected up front (err).
// Config      : KEYTX_RETRY_EN - when defined, a first WAIT timeout triggers
//               one complete resend of the code before giving up.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_tx #(
    parameter int NUM_DIGITS = 6,   // digits per code (1..15), digit 0 sent first
    parameter int GAP_CYCLES = 1,   // idle cycles between digits, 0 = back-to-back
    parameter int TIMEOUT    = 15   // max WAIT cycles for locked==0 (>=1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] code,
    output logic [3:0]              key,
    output logic                    key_valid,
    input  logic                    key_ready,
    input  logic                    locked,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    err
);

    // Counter widths: the gap counter only needs to hold 0..GAP_CYCLES-1,
    // the timer must reach TIMEOUT itself.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    LAST_INDEX = 4'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [3:0]    KEY_IDLE   = 4'hF;
    localparam logic [3:0]    DIGIT_MAX  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SEND  = 3'd2,
        S_GAP   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] code_q,  code_d;
    logic [3:0]              index_q, index_d;
    logic [GW-1:0]           gap_q,   gap_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    pass_q,  pass_d;
    logic                    err_q,   err_d;
`ifdef KEYTX_RETRY_EN
    logic                    retry_q, retry_d;
`endif

    logic [NUM_DIGITS-1:0]   digit_bad;
    logic [3:0]              cur_digit;

    // One flag per stored digit: set when the digit is not a decimal key.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_check
        assign digit_bad[g] = (code_q[4*g +: 4] > DIGIT_MAX);
    end

    // Select the digit addressed by the current index from the captured code.
    always_comb begin
        cur_digit = KEY_IDLE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == 4'(i)) begin
                cur_digit = code_q[4*i +: 4];
            end
        end
    end

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            index_q <= '0;
            gap_q   <= '0;
            timer_q <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef KEYTX_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            index_q <= index_d;
            gap_q   <= gap_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef KEYTX_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Next-state and Moore outputs of the transmit sequencer.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        index_d   = index_q;
        gap_d     = gap_q;
        timer_d   = timer_q;
        pass_d    = pass_q;
        err_d     = err_q;
`ifdef KEYTX_RETRY_EN
        retry_d   = retry_q;
`endif
        key_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    code_d  = code;
                    pass_d  = 1'b0;
                    err_d   = 1'b0;
                    index_d = '0;
                    gap_d   = '0;
                    timer_d = '0;
`ifdef KEYTX_RETRY_EN
                    retry_d = 1'b0;
`endif
                    state_d = S_CHECK;
                end
            end

            // Reject the whole code before anything reaches the bus.
            S_CHECK: begin
                if (|digit_bad) begin
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SEND;
                end
            end

            // key/key_valid stay put until the lock accepts the digit.
            S_SEND: begin
                key_valid = 1'b1;
                if (key_ready) begin
                    if (index_q == LAST_INDEX) begin
                        timer_d = TIMER_ONE;
                        state_d = S_WAIT;
                    end else begin
                        index_d = index_q + 4'd1;
                        if (GAP_CYCLES == 0) begin
                            state_d = S_SEND;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            // An unlock seen on the final timer cycle still counts as a pass.
            S_WAIT: begin
                if (!locked) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (timer_q == TIMER_LAST) begin
`ifdef KEYTX_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        index_d = '0;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = S_DONE;
                    end
`else
                    pass_d  = 1'b0;
                    state_d = S_DONE;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign key  = key_valid ? cur_digit : KEY_IDLE;
    assign pass = pass_q;
    assign err  = err_q;

endmodule
`default_nettype wire
